// File: rtl/gpio_req_pkg.sv
// ============================================================================
// Module : gpio_req_pkg
// Brief  : Shared address map, word stride and FSM states for gpio_req_responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gpio_req_pkg;

  localparam logic [15:0] OUT_BASE    = 16'h0000;
  localparam logic [15:0] IN_BASE     = 16'h1000;
  localparam int          WORD_STRIDE = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // True when addr is word-aligned and falls on one of nwords words above base.
  function automatic logic in_region(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int          nwords);
    int off;
    off = int'({16'h0000, addr}) - int'({16'h0000, base});
    return (off >= 0) && (off < nwords * WORD_STRIDE) && (addr[1:0] == 2'b00);
  endfunction

  function automatic int word_index(input logic [15:0] addr,
                                    input logic [15:0] base);
    int off;
    off = int'({16'h0000, addr}) - int'({16'h0000, base});
    return off / WORD_STRIDE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_sync.sv
// ============================================================================
// Module : gpio_sync
// Brief  : Two-flop synchronizer for asynchronous GPIO input pins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_sync #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/gpio_req_responder.sv
// ============================================================================
// Module : gpio_req_responder
// Brief  : Request/response register port onto GPIO output and input pin banks.
//          Define GPIO_INPUT_SYNC_EN to route gpio_in through a 2-flop synchronizer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_req_responder
  import gpio_req_pkg::*;
#(
  parameter int IWIDTH = 128,
  parameter int OWIDTH = 128,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [15:0]       req_addr,
  input  logic [DW-1:0]     req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DW-1:0]     resp_data,
  output logic              resp_err,
  input  logic [IWIDTH-1:0] gpio_in,
  output logic [OWIDTH-1:0] gpio_out
);

  localparam int OWORDS = OWIDTH / DW;
  localparam int IWORDS = IWIDTH / DW;

  state_e            state_q, state_d;
  logic [OWIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [DW-1:0]     resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [IWIDTH-1:0] gpio_in_s;
  logic              out_hit, in_hit;
  int                out_idx, in_idx;

`ifdef GPIO_INPUT_SYNC_EN
  gpio_sync #(.WIDTH(IWIDTH)) u_gpio_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (gpio_in),
    .q_o   (gpio_in_s)
  );
`else
  assign gpio_in_s = gpio_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gpio_out_q  <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gpio_out_q  <= gpio_out_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gpio_out_d  = gpio_out_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    out_hit     = in_region(req_addr, OUT_BASE, OWORDS);
    in_hit      = in_region(req_addr, IN_BASE, IWORDS);
    out_idx     = word_index(req_addr, OUT_BASE);
    in_idx      = word_index(req_addr, IN_BASE);

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d     = ST_RESP;
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          // Writes land in gpio_out on the accepting edge; reads snapshot now.
          if (out_hit) begin
            for (int k = 0; k < OWORDS; k++) begin
              if (out_idx == k) begin
                if (req_write) gpio_out_d[k*DW +: DW] = req_data;
                else           resp_data_d = gpio_out_q[k*DW +: DW];
              end
            end
          end else if (in_hit) begin
            for (int k = 0; k < IWORDS; k++) begin
              if (in_idx == k && !req_write) resp_data_d = gpio_in_s[k*DW +: DW];
            end
          end else begin
            resp_err_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gpio_out  = gpio_out_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_req_responder.sv
// ============================================================================
// Module : tb_gpio_req_responder
// Brief  : Directed self-checking bench for gpio_req_responder (default build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpio_req_responder;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [15:0]  req_addr;
  logic [31:0]  req_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic         resp_err;
  logic [127:0] gpio_in;
  logic [127:0] gpio_out;

  int total;
  int bad;

  gpio_req_responder #(.IWIDTH(128), .OWIDTH(128), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns one falling edge after acceptance.
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    chk("req_ready_before_accept", {127'b0, req_ready}, 128'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_after_handshake", {127'b0, resp_valid}, 128'd0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    gpio_in    = '0;
    #3;
    chk("rst_gpio_out",   gpio_out,                  128'd0);
    chk("rst_resp_valid", {127'b0, resp_valid},      128'd0);
    chk("rst_resp_data",  {96'b0, resp_data},        128'd0);
    chk("rst_resp_err",   {127'b0, resp_err},        128'd0);
    chk("rst_req_ready",  {127'b0, req_ready},       128'd1);
    @(negedge clk);
    reset = 1'b0;

    // Write output word 1
    issue(1'b1, 16'h0004, 32'hDEADBEEF);
    chk("wr1_resp_valid", {127'b0, resp_valid}, 128'd1);
    chk("wr1_req_ready",  {127'b0, req_ready},  128'd0);
    chk("wr1_resp_err",   {127'b0, resp_err},   128'd0);
    chk("wr1_resp_data",  {96'b0, resp_data},   128'd0);
    chk("wr1_gpio_out",   gpio_out, {64'h0, 32'hDEADBEEF, 32'h0});
    finish_resp();

    // Input word 0 held, pins change after acceptance
    gpio_in = 128'h0000_00A5;
    repeat (3) @(negedge clk);
    issue(1'b0, 16'h1000, 32'h0);
    gpio_in = 128'h0000_00FF;
    chk("rdin0_data", {96'b0, resp_data}, 128'h0000_00A5);
    chk("rdin0_err",  {127'b0, resp_err}, 128'd0);
    @(negedge clk);
    chk("rdin0_data_held", {96'b0, resp_data}, 128'h0000_00A5);
    finish_resp();

    // Top input word boundary
    gpio_in = {32'hCAFEF00D, 96'h0};
    @(negedge clk);
    issue(1'b0, 16'h100C, 32'h0);
    chk("rdin3_data", {96'b0, resp_data}, 128'hCAFEF00D);
    chk("rdin3_err",  {127'b0, resp_err}, 128'd0);
    finish_resp();

    // Output readback
    issue(1'b0, 16'h0004, 32'h0);
    chk("rdout1_data", {96'b0, resp_data}, 128'hDEADBEEF);
    finish_resp();

    // Decode errors
    issue(1'b0, 16'h2000, 32'h0);
    chk("err2000_err",  {127'b0, resp_err}, 128'd1);
    chk("err2000_data", {96'b0, resp_data}, 128'd0);
    finish_resp();
    issue(1'b0, 16'h0002, 32'h0);
    chk("err0002_err",  {127'b0, resp_err}, 128'd1);
    chk("err0002_data", {96'b0, resp_data}, 128'd0);
    finish_resp();
    issue(1'b1, 16'h0006, 32'h55555555);
    chk("err0006_err", {127'b0, resp_err}, 128'd1);
    chk("err0006_gpio_out", gpio_out, {64'h0, 32'hDEADBEEF, 32'h0});
    finish_resp();
    issue(1'b1, 16'h0010, 32'h66666666);
    chk("err0010_err", {127'b0, resp_err}, 128'd1);
    chk("err0010_gpio_out", gpio_out, {64'h0, 32'hDEADBEEF, 32'h0});
    finish_resp();
    issue(1'b0, 16'h1010, 32'h0);
    chk("err1010_err", {127'b0, resp_err}, 128'd1);
    finish_resp();

    // Write to input region is ignored without error
    issue(1'b1, 16'h1000, 32'h77777777);
    chk("wrin_err",      {127'b0, resp_err}, 128'd0);
    chk("wrin_data",     {96'b0, resp_data}, 128'd0);
    chk("wrin_gpio_out", gpio_out, {64'h0, 32'hDEADBEEF, 32'h0});
    finish_resp();

    // Back-pressure: response held 5 cycles, competing request refused
    issue(1'b0, 16'h0004, 32'h0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0000;
    req_data  = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {127'b0, resp_valid}, 128'd1);
      chk("bp_req_ready",  {127'b0, req_ready},  128'd0);
      chk("bp_resp_data",  {96'b0, resp_data},   128'hDEADBEEF);
      @(negedge clk);
    end
    req_valid = 1'b0;
    finish_resp();
    chk("bp_gpio_out", gpio_out, {64'h0, 32'hDEADBEEF, 32'h0});

    // Back-to-back write then read of word 3 with resp_ready high
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 16'h000C;
    req_data   = 32'h12345678;
    @(negedge clk);
    chk("b2b_wr_resp_valid", {127'b0, resp_valid}, 128'd1);
    chk("b2b_wr_err",        {127'b0, resp_err},   128'd0);
    req_write = 1'b0;
    req_data  = 32'h0;
    @(negedge clk);
    chk("b2b_idle_req_ready", {127'b0, req_ready}, 128'd1);
    chk("b2b_gpio_out", gpio_out, {32'h12345678, 32'h0, 32'hDEADBEEF, 32'h0});
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_rd_resp_valid", {127'b0, resp_valid}, 128'd1);
    chk("b2b_rd_data",       {96'b0, resp_data},   128'h12345678);
    @(negedge clk);
    chk("b2b_done_resp_valid", {127'b0, resp_valid}, 128'd0);
    resp_ready = 1'b0;

    // Reset while a response is pending
    issue(1'b1, 16'h0000, 32'hAAAA5555);
    chk("rstmid_pre_gpio_out", gpio_out, {32'h12345678, 32'h0, 32'hDEADBEEF, 32'hAAAA5555});
    chk("rstmid_pre_resp_valid", {127'b0, resp_valid}, 128'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_resp_valid", {127'b0, resp_valid}, 128'd0);
    chk("rstmid_gpio_out",   gpio_out,             128'd0);
    chk("rstmid_resp_data",  {96'b0, resp_data},   128'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_req_ready", {127'b0, req_ready}, 128'd1);
    issue(1'b0, 16'h000C, 32'h0);
    chk("rstmid_rd3_data", {96'b0, resp_data}, 128'd0);
    finish_resp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gpio_req_responder.md
GPIO_REQ_RESPONDER -- requirements
Module: gpio_req_responder

Interface
REQ-001 SHALL have parameter IWIDTH, default 128: width of the sampled input pin bus.
REQ-002 SHALL have parameter OWIDTH, default 128: width of the driven output pin bus.
REQ-003 SHALL have parameter DW, default 32: request/response data word width; IWIDTH and OWIDTH multiples of DW.
REQ-004 SHALL have port clk  input  1  sole clock, all flops rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req_valid/req_ready  input/output  1  request handshake, transfer when both high on a clk edge.
REQ-007 SHALL have port req_write  input  1  1=write outputs, 0=read.
REQ-008 SHALL have port req_addr  input  16  byte address, word-aligned.
REQ-009 SHALL have port req_data  input  DW  write data.
REQ-010 SHALL have ports resp_valid/resp_ready  output/input  1  response handshake.
REQ-011 SHALL have port resp_data  output  DW  read data, 0 for writes.
REQ-012 SHALL have port resp_err  output  1  address decode error.
REQ-013 SHALL have port gpio_in  input  IWIDTH  pins driven by the device under control.
REQ-014 SHALL have port gpio_out  output  OWIDTH  pins driving the device under control.

Function
REQ-015 SHALL implement FSM IDLE -> RESP; IDLE: req_ready=1, resp_valid=0; RESP: req_ready=0, resp_valid=1.
REQ-016 SHALL transition IDLE->RESP on req handshake; RESP->IDLE on resp handshake; otherwise hold state and all response outputs stable.
REQ-017 SHALL present the response the cycle after request acceptance (latency 1), one outstanding request max.
REQ-018 SHALL decode: 0x0000 + 4k, k < OWIDTH/DW, = output word k (write sets gpio_out[k*DW +: DW]; read returns current value).
REQ-019 SHALL decode: 0x1000 + 4k, k < IWIDTH/DW, = input word k (read returns sampled gpio_in word; write ignored, no error).
REQ-020 SHALL flag any other address, or addr[1:0] != 0, with resp_err=1, resp_data=0, no state change.
REQ-021 SHALL update gpio_out on the same clk edge the write request is accepted.
REQ-022 SHALL capture read data at request acceptance; later pin changes do not alter a pending response.
REQ-023 SHALL make an output-readback issued immediately after a write to the same word return the new value.

Reset
REQ-024 SHALL, on reset assertion, immediately force state IDLE, gpio_out=0, resp_valid=0, resp_data=0, resp_err=0, synchronizer flops 0.
REQ-025 SHALL discard an in-flight response if reset asserts mid-transaction; first post-reset cycle has req_ready=1.

Configuration
REQ-026 SHALL, with GPIO_INPUT_SYNC_EN defined, pass gpio_in through a 2-flop synchronizer before reads (2-cycle sampling delay).
REQ-027 SHALL, without GPIO_INPUT_SYNC_EN, sample gpio_in directly at request acceptance.

Structure
REQ-028 SHALL place the address-region bases (0x0000, 0x1000), word stride (4) and FSM state enum in shared package gpio_req_pkg.
REQ-029 SHALL implement the synchronizer as sub-module gpio_sync (parameter WIDTH), instantiated only under GPIO_INPUT_SYNC_EN.

Verification
REQ-030 SHALL cover: write 0xDEADBEEF to 0x0004 -> gpio_out[63:32]=0xDEADBEEF next edge, resp_err=0, resp_data=0.
REQ-031 SHALL cover: gpio_in=0x...0000_00A5 held 3 cycles, read 0x1000 -> resp_data=0x000000A5 one cycle after accept.
REQ-032 SHALL cover: read 0x2000 and read 0x0002 -> resp_err=1, resp_data=0, gpio_out unchanged.
REQ-033 SHALL cover: resp_ready held low 5 cycles -> resp_valid/resp_data stable, req_ready=0 throughout, new req_valid not accepted.
REQ-034 SHALL cover: back-to-back write 0x12345678 to 0x000C then read 0x000C with resp_ready=1 -> read returns 0x12345678, one transaction per 2 cycles.
REQ-035 SHALL cover: reset asserted while in RESP -> resp_valid=0 and gpio_out=0 asynchronously, req_ready=1 after release.
